// File: rtl/tinker_pkg.sv
// Shared types and constants for the tinker multi-cycle sequencer.
// Holds the FSM state encoding, opcode map and field helpers.
package tinker_pkg;

  localparam int INSTR_W = 32;
  localparam int XLEN    = 64;

  typedef enum logic [2:0] {
    ST_FETCH     = 3'd0,
    ST_DECODE    = 3'd1,
    ST_EXECUTE   = 3'd2,
    ST_MEM       = 3'd3,
    ST_WRITEBACK = 3'd4,
    ST_HALT      = 3'd5,
    ST_FAULT     = 3'd6
  } state_e;

  localparam logic [4:0] OP_HALT     = 5'h0F;
  localparam logic [4:0] OP_LOAD     = 5'h10;
  localparam logic [4:0] OP_STORE    = 5'h13;
  localparam logic [4:0] OP_BR_FIRST = 5'h08;
  localparam logic [4:0] OP_BR_LAST  = 5'h0F;

  function automatic logic [4:0] opcode_of(
    input logic [INSTR_W-1:0] ins
  );
    return ins[31:27];
  endfunction

  function automatic logic [11:0] literal_of(
    input logic [INSTR_W-1:0] ins
  );
    return ins[11:0];
  endfunction

endpackage

// File: rtl/tinker_sequencer_if.sv
// Bundle of fetch, data-memory and datapath signals around the sequencer.
// master = sequencer side, slave = memory/datapath side.
interface tinker_sequencer_if;
  import tinker_pkg::*;

  logic               imem_req;
  logic [XLEN-1:0]    imem_addr;
  logic               imem_ack;
  logic [INSTR_W-1:0] imem_rdata;
  logic [INSTR_W-1:0] instruction;
  logic               dmem_req;
  logic               dmem_we;
  logic               dmem_ack;
  logic               branch_taken;
  logic [XLEN-1:0]    branch_target;
  logic               reg_write_en;
  logic [XLEN-1:0]    pc;
  logic               instr_retired;
  logic               halt;
  logic               fault;
  logic [2:0]         state_dbg;

  modport master (
    output imem_req, imem_addr, instruction,
    output dmem_req, dmem_we, reg_write_en,
    output pc, instr_retired, halt, fault,
    output state_dbg,
    input  imem_ack, imem_rdata, dmem_ack,
    input  branch_taken, branch_target
  );

  modport slave (
    input  imem_req, imem_addr, instruction,
    input  dmem_req, dmem_we, reg_write_en,
    input  pc, instr_retired, halt, fault,
    input  state_dbg,
    output imem_ack, imem_rdata, dmem_ack,
    output branch_taken, branch_target
  );

endinterface

// File: rtl/tinker_timeout_counter.sv
// Wait-cycle counter for outstanding memory requests.
// expired_o flags the last permitted unacknowledged cycle.
module tinker_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic clk,
  input  logic reset,
  input  logic count_en_i,
  input  logic clear_i,
  output logic expired_o
);

  localparam int CW = (TIMEOUT_CYCLES > 2) ?
                      $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i)
      count_d = '0;
    else if (count_en_i)
      count_d = count_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset)
      count_q <= '0;
    else
      count_q <= count_d;
  end

  assign expired_o = (count_q == LAST);

endmodule

// File: rtl/tinker_sequencer.sv
// Multi-cycle control FSM for the tinker core: owns PC and IR,
// fetches, sequences decode/execute/mem/writeback, gates reg writes.
module tinker_sequencer
  import tinker_pkg::*;
#(
  parameter logic [63:0] RESET_PC       = 64'h2000,
  parameter int          TIMEOUT_CYCLES = 256
) (
  input  logic                clk,
  input  logic                reset,
  tinker_sequencer_if.master  bus
);

  state_e             state_q, state_d;
  logic [XLEN-1:0]    pc_q, pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic               count_en;
  logic               expired;
  logic [4:0]         op;
  logic               is_mem;
  logic               no_wb;

  assign op     = opcode_of(instr_q);
  assign is_mem = (op == OP_LOAD) || (op == OP_STORE);
  assign no_wb  = ((op >= OP_BR_FIRST) && (op <= OP_BR_LAST))
               || (op == OP_STORE);

  tinker_timeout_counter #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_tmo (
    .clk        (clk),
    .reset      (reset),
    .count_en_i (count_en),
    .clear_i    (!count_en || (state_d != state_q)),
    .expired_o  (expired)
  );

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    count_en = 1'b0;
    unique case (state_q)
      ST_FETCH: begin
        count_en = !bus.imem_ack;
        if (bus.imem_ack) begin
          instr_d = bus.imem_rdata;
          state_d = ST_DECODE;
        end else if (expired) begin
          state_d = ST_FAULT;
        end
      end
      ST_DECODE: begin
        if (op == OP_HALT && literal_of(instr_q) == 12'd0)
          state_d = ST_HALT;
        else
          state_d = ST_EXECUTE;
      end
      ST_EXECUTE: begin
        state_d = is_mem ? ST_MEM : ST_WRITEBACK;
      end
      ST_MEM: begin
        count_en = !bus.dmem_ack;
        if (bus.dmem_ack)
          state_d = ST_WRITEBACK;
        else if (expired)
          state_d = ST_FAULT;
      end
      ST_WRITEBACK: begin
        pc_d    = bus.branch_taken ? bus.branch_target
                                   : pc_q + 64'd4;
        state_d = ST_FETCH;
      end
      ST_HALT, ST_FAULT: begin
        state_d = state_q;
      end
      default: begin
        state_d = ST_FAULT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_FETCH;
      pc_q    <= RESET_PC;
      instr_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  // Strobes are held low for the whole reset cycle.
  assign bus.imem_req      = !reset && (state_q == ST_FETCH);
  assign bus.imem_addr     = pc_q;
  assign bus.dmem_req      = !reset && (state_q == ST_MEM);
  assign bus.dmem_we       = !reset && (state_q == ST_MEM)
                          && (op == OP_STORE);
  assign bus.reg_write_en  = !reset && (state_q == ST_WRITEBACK)
                          && !no_wb;
  assign bus.instr_retired = !reset && (state_q == ST_WRITEBACK);
  assign bus.instruction   = instr_q;
  assign bus.pc            = pc_q;
  assign bus.halt          = (state_q == ST_HALT);
  assign bus.fault         = (state_q == ST_FAULT);
  assign bus.state_dbg     = state_q;

endmodule

// File: tb/tb_tinker_sequencer.sv
// Directed bench for tinker_sequencer: ALU, load/store, branch,
// halt, fetch timeout and reset-during-MEM sequences.
module tb_tinker_sequencer;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   fails  = 0;

  tinker_sequencer_if bus ();

  tinker_sequencer #(
    .RESET_PC       (64'h2000),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic expect_eq(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Starts at a negedge in FETCH, ends at a negedge in the next FETCH.
  task automatic run_instr(
    input logic [31:0] ins,
    input logic        bt,
    input logic [63:0] tgt,
    input int          mw,
    input logic        exp_rwe,
    input logic        exp_we,
    input logic [63:0] exp_pc
  );
    expect_eq("f_state", 64'(bus.state_dbg), 64'd0);
    expect_eq("f_req", 64'(bus.imem_req), 64'd1);
    expect_eq("f_rwe", 64'(bus.reg_write_en), 64'd0);
    bus.imem_ack      = 1'b1;
    bus.imem_rdata    = ins;
    bus.branch_taken  = bt;
    bus.branch_target = tgt;
    @(negedge clk);
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = 32'h0;
    expect_eq("d_state", 64'(bus.state_dbg), 64'd1);
    expect_eq("d_ir", 64'(bus.instruction), 64'(ins));
    expect_eq("d_rwe", 64'(bus.reg_write_en), 64'd0);
    @(negedge clk);
    expect_eq("x_state", 64'(bus.state_dbg), 64'd2);
    expect_eq("x_rwe", 64'(bus.reg_write_en), 64'd0);
    expect_eq("x_ret", 64'(bus.instr_retired), 64'd0);
    if (mw >= 0) begin
      for (int i = 0; i <= mw; i++) begin
        @(negedge clk);
        expect_eq("m_state", 64'(bus.state_dbg), 64'd3);
        expect_eq("m_req", 64'(bus.dmem_req), 64'd1);
        expect_eq("m_we", 64'(bus.dmem_we), 64'(exp_we));
        expect_eq("m_rwe", 64'(bus.reg_write_en), 64'd0);
        if (i == mw) bus.dmem_ack = 1'b1;
      end
    end
    @(negedge clk);
    bus.dmem_ack = 1'b0;
    expect_eq("w_state", 64'(bus.state_dbg), 64'd4);
    expect_eq("w_rwe", 64'(bus.reg_write_en), 64'(exp_rwe));
    expect_eq("w_ret", 64'(bus.instr_retired), 64'd1);
    expect_eq("w_ir", 64'(bus.instruction), 64'(ins));
    expect_eq("w_dreq", 64'(bus.dmem_req), 64'd0);
    @(negedge clk);
    expect_eq("n_state", 64'(bus.state_dbg), 64'd0);
    expect_eq("n_pc", bus.pc, exp_pc);
    expect_eq("n_addr", bus.imem_addr, exp_pc);
    expect_eq("n_ret", 64'(bus.instr_retired), 64'd0);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
  endtask

  initial begin
    reset             = 1'b1;
    bus.imem_ack      = 1'b0;
    bus.imem_rdata    = 32'h0;
    bus.dmem_ack      = 1'b0;
    bus.branch_taken  = 1'b0;
    bus.branch_target = 64'h0;
    repeat (2) @(negedge clk);
    expect_eq("rst_state", 64'(bus.state_dbg), 64'd0);
    expect_eq("rst_pc", bus.pc, 64'h2000);
    expect_eq("rst_ir", 64'(bus.instruction), 64'd0);
    expect_eq("rst_ireq", 64'(bus.imem_req), 64'd0);
    expect_eq("rst_dreq", 64'(bus.dmem_req), 64'd0);
    expect_eq("rst_rwe", 64'(bus.reg_write_en), 64'd0);
    expect_eq("rst_ret", 64'(bus.instr_retired), 64'd0);
    expect_eq("rst_halt", 64'(bus.halt), 64'd0);
    expect_eq("rst_fault", 64'(bus.fault), 64'd0);
    reset = 1'b0;
    #1;
    expect_eq("first_addr", bus.imem_addr, 64'h2000);

    run_instr(32'hC0443000, 1'b0, 64'h0, -1, 1'b1, 1'b0, 64'h2004);
    run_instr(32'h80000000, 1'b0, 64'h0, 3, 1'b1, 1'b0, 64'h2008);
    run_instr(32'h98000000, 1'b0, 64'h0, 0, 1'b0, 1'b1, 64'h200C);
    run_instr(32'h40000000, 1'b1, 64'h3000, -1, 1'b0, 1'b0,
              64'h3000);
    run_instr(32'h40000000, 1'b0, 64'h3000, -1, 1'b0, 1'b0,
              64'h3004);

    bus.imem_ack   = 1'b1;
    bus.imem_rdata = 32'h78000000;
    @(negedge clk);
    expect_eq("h_dec", 64'(bus.state_dbg), 64'd1);
    expect_eq("h_halt0", 64'(bus.halt), 64'd0);
    @(negedge clk);
    expect_eq("h_state", 64'(bus.state_dbg), 64'd5);
    expect_eq("h_halt", 64'(bus.halt), 64'd1);
    for (int i = 0; i < 20; i++) begin
      expect_eq("h_ireq", 64'(bus.imem_req), 64'd0);
      @(negedge clk);
    end
    bus.imem_ack = 1'b0;
    expect_eq("h_sticky", 64'(bus.halt), 64'd1);
    expect_eq("h_pc", bus.pc, 64'h3004);
    expect_eq("h_ir", 64'(bus.instruction), 64'h78000000);
    pulse_reset();
    expect_eq("hr_state", 64'(bus.state_dbg), 64'd0);
    expect_eq("hr_pc", bus.pc, 64'h2000);
    expect_eq("hr_halt", 64'(bus.halt), 64'd0);

    for (int i = 0; i < 8; i++) begin
      expect_eq("t_wait", 64'(bus.state_dbg), 64'd0);
      expect_eq("t_nofault", 64'(bus.fault), 64'd0);
      @(negedge clk);
    end
    expect_eq("t_state", 64'(bus.state_dbg), 64'd6);
    expect_eq("t_fault", 64'(bus.fault), 64'd1);
    repeat (3) @(negedge clk);
    expect_eq("t_sticky", 64'(bus.fault), 64'd1);
    expect_eq("t_ireq", 64'(bus.imem_req), 64'd0);
    pulse_reset();
    expect_eq("tr_fault", 64'(bus.fault), 64'd0);

    for (int i = 0; i < 8; i++) begin
      expect_eq("a_wait", 64'(bus.state_dbg), 64'd0);
      if (i == 7) begin
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = 32'hC0443000;
      end
      @(negedge clk);
    end
    bus.imem_ack = 1'b0;
    expect_eq("a_state", 64'(bus.state_dbg), 64'd1);
    expect_eq("a_fault", 64'(bus.fault), 64'd0);
    pulse_reset();

    bus.imem_ack   = 1'b1;
    bus.imem_rdata = 32'h80000000;
    @(negedge clk);
    bus.imem_ack = 1'b0;
    @(negedge clk);
    @(negedge clk);
    expect_eq("rm_state", 64'(bus.state_dbg), 64'd3);
    reset        = 1'b1;
    bus.dmem_ack = 1'b1;
    @(negedge clk);
    reset        = 1'b0;
    bus.dmem_ack = 1'b0;
    #1;
    expect_eq("rm_next", 64'(bus.state_dbg), 64'd0);
    expect_eq("rm_pc", bus.pc, 64'h2000);
    expect_eq("rm_rwe", 64'(bus.reg_write_en), 64'd0);
    expect_eq("rm_ret", 64'(bus.instr_retired), 64'd0);
    expect_eq("rm_ireq", 64'(bus.imem_req), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule

// File: doc/tinker_sequencer.md
Name: tinker_sequencer

Overview:
Multi-cycle control FSM that sequences the combinational tinker datapath (decoder, register file, ALU) one instruction at a time. It owns the PC and the instruction register. It fetches over an instruction-memory req/ack handshake, steps through decode/execute/memory/writeback, and gates register writes. It sits beside the datapath inside the core top level, replacing the always-on register write.

Parameters:
RESET_PC, 64'h2000, PC value loaded on reset
TIMEOUT_CYCLES, 256, max cycles a memory request may stay unacknowledged before FAULT (≥2)

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
imem_req  out  1  instruction fetch request
imem_addr  out  64  fetch address (= pc)
imem_ack  in  1  fetch data valid this cycle
imem_rdata  in  32  fetched instruction
instruction  out  32  instruction register to decoder
dmem_req  out  1  data memory request
dmem_we  out  1  data request is a store
dmem_ack  in  1  data access complete
branch_taken  in  1  datapath: next PC is branch_target
branch_target  in  64  datapath branch target
reg_write_en  out  1  register-file write strobe
pc  out  64  current PC
instr_retired  out  1  one-cycle pulse per completed instruction
halt  out  1  sticky halt
fault  out  1  sticky memory timeout
state_dbg  out  3  current state encoding

Behaviour:
- Instruction fields: opcode [31:27], literal [11:0].
- Reset is synchronous and active-high, and wins over all other events, including a mid-handshake ack.
- Reset values: state FETCH, pc=RESET_PC, instruction=0, halt=0, fault=0, timeout count=0. All strobes (imem_req, dmem_req, dmem_we, reg_write_en, instr_retired) are 0.
- States: FETCH=0, DECODE=1, EXECUTE=2, MEM=3, WRITEBACK=4, HALT=5, FAULT=6.
- FETCH:
  - imem_req=1, imem_addr=pc.
  - On a clock edge with imem_ack=1: instruction<=imem_rdata, go to DECODE.
  - Otherwise stay in FETCH.
- DECODE (1 cycle):
  - opcode==5'h0F and literal==0 → HALT.
  - Otherwise → EXECUTE.
- EXECUTE (1 cycle), lets the datapath settle:
  - opcode 5'h10 (load) or 5'h13 (store) → MEM.
  - Otherwise → WRITEBACK.
- MEM:
  - dmem_req=1; dmem_we=1 only for opcode 5'h13.
  - On dmem_ack → WRITEBACK.
- WRITEBACK (1 cycle):
  - reg_write_en=1 unless opcode is in 5'h08–5'h0F or is 5'h13.
  - pc <= branch_taken ? branch_target : pc+4. The +4 wraps modulo 2^64; no alignment check.
  - instr_retired=1; → FETCH.
- Timeout:
  - The counter increments each cycle in FETCH or MEM without ack, and clears on ack or on any state change.
  - If the counter equals TIMEOUT_CYCLES-1 and ack is still 0: → FAULT, fault=1.
  - An ack arriving on the same edge as the timeout takes priority; no fault is raised.
- HALT and FAULT:
  - Terminal. All strobes are 0; pc and instruction are frozen. Only reset exits.
  - halt=1 in HALT; fault=1 in FAULT.
- instruction is stable from DECODE through WRITEBACK.
- imem_ack outside FETCH and dmem_ack outside MEM are ignored.
- Latency with zero-wait ack: non-memory instruction 4 cycles (FETCH, DECODE, EXECUTE, WRITEBACK); load/store 5 cycles.

Decomposition:
- tinker_pkg holds:
  - the state enum (3-bit);
  - opcode constants OP_HALT=5'h0F, OP_LOAD=5'h10, OP_STORE=5'h13, OP_BR_FIRST=5'h08, OP_BR_LAST=5'h0F;
  - INSTR_W=32, XLEN=64.
- One sub-module, tinker_timeout_counter: clk/reset/count_en/clear in, expired out, parameterised by TIMEOUT_CYCLES.

Test Plan:
- Reset, then imem_rdata=32'hC0443000 (add r1,r2,r3) with ack in the first FETCH cycle → imem_addr=0x2000; reg_write_en and instr_retired high exactly in cycle 4; pc=0x2004 afterwards.
- Load 32'h80000000 with dmem_ack 3 cycles after dmem_req → dmem_we=0; reg_write_en in WRITEBACK. Store 32'h98000000 → dmem_we=1; reg_write_en never asserts; pc+4.
- Branch 32'h40000000 with branch_taken=1, branch_target=0x3000 → no reg_write_en; next imem_addr=0x3000. Same instruction with branch_taken=0 → next imem_addr=pc+4.
- Fetch 32'h78000000 → halt=1 after DECODE; imem_req stays 0 for 20 cycles; reset → state FETCH, pc=0x2000, halt=0.
- TIMEOUT_CYCLES=8, imem_ack held low → fault=1 after the 8th FETCH cycle. Repeat with ack on the 8th cycle → no fault; DECODE entered.
- Reset asserted in MEM while dmem_ack=1 → next state FETCH, pc=RESET_PC, no reg_write_en or instr_retired pulse.
